// File: rtl/alu_pkg.sv
// Shared definitions for the ALU dispatcher: unit-select codes, FSM encoding and
// timeout defaults.
package alu_pkg;

  typedef enum logic [1:0] {
    UnitArith = 2'b00,
    UnitLogic = 2'b01,
    UnitCmp   = 2'b10,
    UnitShift = 2'b11
  } unit_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StIssue = 2'b01,
    StWait  = 2'b10,
    StHold  = 2'b11
  } state_e;

  localparam int unsigned DefaultTimeout = 15;
  // Wide enough for the largest supported timeout (255).
  localparam int unsigned TimerWidth     = 8;

endpackage

// File: rtl/dispatch_timer.sv
// Wait-cycle counter for the dispatcher; tc flags the Max-th enabled cycle since
// the last clear.
module dispatch_timer
  import alu_pkg::*;
#(
  parameter int unsigned Max = DefaultTimeout
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [TimerWidth-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + TimerWidth'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = en && (count_q == TimerWidth'(Max - 1));

endmodule

// File: rtl/alu_dispatch.sv
// Single-outstanding-request dispatcher: issues one operation to the selected unit,
// waits for its flag (or times out) and holds the zero-extended result for the consumer.
module alu_dispatch
  import alu_pkg::*;
#(
  parameter int unsigned IN_WIDTH = 8,
  parameter int unsigned TIMEOUT  = DefaultTimeout
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [IN_WIDTH-1:0]   IN_A,
  input  logic [IN_WIDTH-1:0]   IN_B,
  input  logic [3:0]            IN_FUN,
  output logic [IN_WIDTH-1:0]   UNIT_A,
  output logic [IN_WIDTH-1:0]   UNIT_B,
  output logic [1:0]            UNIT_FUN,
  output logic [3:0]            UNIT_EN,
  input  logic [3:0]            UNIT_FLAG,
  input  logic [2*IN_WIDTH-1:0] ARITH_OUT,
  input  logic [IN_WIDTH-1:0]   LOGIC_OUT,
  input  logic [3:0]            CMP_OUT,
  input  logic [IN_WIDTH-1:0]   SHIFT_OUT,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [2*IN_WIDTH-1:0] OUT_RESULT,
  output logic [1:0]            OUT_UNIT,
  output logic                  OUT_ERR
);

  localparam int unsigned ResWidth = 2 * IN_WIDTH;

  state_e                state_q, state_d;
  unit_e                 sel_q, sel_d;
  logic [IN_WIDTH-1:0]   unit_a_q, unit_a_d, unit_b_q, unit_b_d;
  logic [1:0]            unit_fun_q, unit_fun_d;
  logic [ResWidth-1:0]   res_q, res_d, sel_res;
  logic                  err_q, err_d;
  // Holds IN_READY low until the first clock edge after reset release.
  logic                  init_q;
  logic                  timer_tc;

  dispatch_timer #(
    .Max (TIMEOUT)
  ) u_timer (
    .CLK (CLK),
    .RST (RST),
    .clr (state_q != StWait),
    .en  (state_q == StWait),
    .tc  (timer_tc)
  );

  always_comb begin
    sel_res = '0;
    unique case (sel_q)
      UnitArith: sel_res = ARITH_OUT;
      UnitLogic: sel_res = {{IN_WIDTH{1'b0}}, LOGIC_OUT};
      UnitCmp:   sel_res = {{(ResWidth - 4){1'b0}}, CMP_OUT};
      UnitShift: sel_res = {{IN_WIDTH{1'b0}}, SHIFT_OUT};
      default:   sel_res = '0;
    endcase
  end

  assign IN_READY = (state_q == StIdle) && init_q;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    unit_a_d   = unit_a_q;
    unit_b_d   = unit_b_q;
    unit_fun_d = unit_fun_q;
    res_d      = res_q;
    err_d      = err_q;
    UNIT_EN    = '0;
    unique case (state_q)
      StIdle: begin
        if (IN_VALID && IN_READY) begin
          sel_d      = unit_e'(IN_FUN[3:2]);
          unit_a_d   = IN_A;
          unit_b_d   = IN_B;
          unit_fun_d = IN_FUN[1:0];
          state_d    = StIssue;
        end
      end
      StIssue: begin
        UNIT_EN = 4'b0001 << sel_q;
        state_d = StWait;
      end
      StWait: begin
        // A flag arriving on the terminal-count cycle still counts as success.
        if (UNIT_FLAG[sel_q]) begin
          res_d   = sel_res;
          err_d   = 1'b0;
          state_d = StHold;
        end else if (timer_tc) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
        if (OUT_READY) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= StIdle;
      sel_q      <= UnitArith;
      unit_a_q   <= '0;
      unit_b_q   <= '0;
      unit_fun_q <= '0;
      res_q      <= '0;
      err_q      <= 1'b0;
      init_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      unit_a_q   <= unit_a_d;
      unit_b_q   <= unit_b_d;
      unit_fun_q <= unit_fun_d;
      res_q      <= res_d;
      err_q      <= err_d;
      init_q     <= 1'b1;
    end
  end

  assign UNIT_A     = unit_a_q;
  assign UNIT_B     = unit_b_q;
  assign UNIT_FUN   = unit_fun_q;
  assign OUT_VALID  = (state_q == StHold);
  assign OUT_RESULT = res_q;
  assign OUT_UNIT   = sel_q;
  assign OUT_ERR    = err_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch: hand-computed vectors for compare, arith, backpressure,
// wrong-unit flags, timeout, flag-on-timeout and mid-operation reset.
module tb_alu_dispatch;

  localparam int unsigned W  = 8;
  localparam int unsigned TO = 15;

  logic           CLK;
  logic           RST;
  logic           IN_VALID;
  logic           IN_READY;
  logic [W-1:0]   IN_A;
  logic [W-1:0]   IN_B;
  logic [3:0]     IN_FUN;
  logic [W-1:0]   UNIT_A;
  logic [W-1:0]   UNIT_B;
  logic [1:0]     UNIT_FUN;
  logic [3:0]     UNIT_EN;
  logic [3:0]     UNIT_FLAG;
  logic [2*W-1:0] ARITH_OUT;
  logic [W-1:0]   LOGIC_OUT;
  logic [3:0]     CMP_OUT;
  logic [W-1:0]   SHIFT_OUT;
  logic           OUT_VALID;
  logic           OUT_READY;
  logic [2*W-1:0] OUT_RESULT;
  logic [1:0]     OUT_UNIT;
  logic           OUT_ERR;

  int n_cmp = 0;
  int n_err = 0;

  alu_dispatch #(
    .IN_WIDTH (W),
    .TIMEOUT  (TO)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .IN_A       (IN_A),
    .IN_B       (IN_B),
    .IN_FUN     (IN_FUN),
    .UNIT_A     (UNIT_A),
    .UNIT_B     (UNIT_B),
    .UNIT_FUN   (UNIT_FUN),
    .UNIT_EN    (UNIT_EN),
    .UNIT_FLAG  (UNIT_FLAG),
    .ARITH_OUT  (ARITH_OUT),
    .LOGIC_OUT  (LOGIC_OUT),
    .CMP_OUT    (CMP_OUT),
    .SHIFT_OUT  (SHIFT_OUT),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .OUT_RESULT (OUT_RESULT),
    .OUT_UNIT   (OUT_UNIT),
    .OUT_ERR    (OUT_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST       = 1'b0;
    IN_VALID  = 1'b0;
    IN_A      = '0;
    IN_B      = '0;
    IN_FUN    = '0;
    UNIT_FLAG = '0;
    ARITH_OUT = '0;
    LOGIC_OUT = '0;
    CMP_OUT   = '0;
    SHIFT_OUT = '0;
    OUT_READY = 1'b0;

    // Reset state
    #2;
    check("rst_in_ready", 32'(IN_READY), 0);
    check("rst_unit_en", 32'(UNIT_EN), 0);
    check("rst_out_valid", 32'(OUT_VALID), 0);
    check("rst_out_result", 32'(OUT_RESULT), 0);
    check("rst_unit_a", 32'(UNIT_A), 0);
    RST = 1'b1;
    tick();
    check("ready_after_first_edge", 32'(IN_READY), 1);

    // Compare: 5 vs 5, fun 1001, flag one cycle after enable
    IN_VALID = 1'b1; IN_A = 8'd5; IN_B = 8'd5; IN_FUN = 4'b1001;
    tick();
    IN_VALID = 1'b0;
    check("cmp_issue_en", 32'(UNIT_EN), 'b0100);
    check("cmp_issue_ready", 32'(IN_READY), 0);
    check("cmp_unit_a", 32'(UNIT_A), 5);
    check("cmp_unit_b", 32'(UNIT_B), 5);
    check("cmp_unit_fun", 32'(UNIT_FUN), 1);
    tick();
    check("cmp_wait_en", 32'(UNIT_EN), 0);
    check("cmp_wait_valid", 32'(OUT_VALID), 0);
    UNIT_FLAG = 4'b0100; CMP_OUT = 4'd1;
    tick();
    UNIT_FLAG = '0;
    check("cmp_valid", 32'(OUT_VALID), 1);
    check("cmp_result", 32'(OUT_RESULT), 'h0001);
    check("cmp_unit", 32'(OUT_UNIT), 2);
    check("cmp_err", 32'(OUT_ERR), 0);
    OUT_READY = 1'b1;
    #1;
    check("hold_release_no_ready", 32'(IN_READY), 0);
    tick();
    OUT_READY = 1'b0;
    check("cmp_idle_valid", 32'(OUT_VALID), 0);
    check("cmp_idle_ready", 32'(IN_READY), 1);

    // Arith: 0xFF + 0xFF style result 0x01FE
    IN_VALID = 1'b1; IN_A = 8'hFF; IN_B = 8'hFF; IN_FUN = 4'b0000;
    tick();
    IN_VALID = 1'b0;
    check("arith_issue_en", 32'(UNIT_EN), 'b0001);
    tick();
    UNIT_FLAG = 4'b0001; ARITH_OUT = 16'h01FE;
    tick();
    UNIT_FLAG = '0;
    check("arith_valid", 32'(OUT_VALID), 1);
    check("arith_result", 32'(OUT_RESULT), 'h01FE);
    check("arith_unit", 32'(OUT_UNIT), 0);

    // Backpressure: consumer stalls 10 cycles while a logic request waits
    IN_VALID = 1'b1; IN_A = 8'hF0; IN_B = 8'h3C; IN_FUN = 4'b0110;
    ARITH_OUT = 16'hBEEF;
    for (int i = 0; i < 10; i++) begin
      check("bp_in_ready", 32'(IN_READY), 0);
      check("bp_valid", 32'(OUT_VALID), 1);
      check("bp_result", 32'(OUT_RESULT), 'h01FE);
      check("bp_unit_a", 32'(UNIT_A), 'hFF);
      tick();
    end
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    check("bp_idle_ready", 32'(IN_READY), 1);
    check("bp_idle_unit_a_held", 32'(UNIT_A), 'hFF);

    // Wrong-unit flags on the logic request are ignored
    tick();
    IN_VALID = 1'b0;
    check("logic_issue_en", 32'(UNIT_EN), 'b0010);
    check("logic_unit_a", 32'(UNIT_A), 'hF0);
    check("logic_unit_fun", 32'(UNIT_FUN), 2);
    UNIT_FLAG = 4'b0100; CMP_OUT = 4'hF; LOGIC_OUT = 8'h30;
    tick();
    tick();
    check("wrong_flag_cmp", 32'(OUT_VALID), 0);
    UNIT_FLAG = 4'b1001;
    tick();
    check("wrong_flag_arith_shift", 32'(OUT_VALID), 0);
    UNIT_FLAG = 4'b0010;
    tick();
    UNIT_FLAG = '0;
    check("logic_valid", 32'(OUT_VALID), 1);
    check("logic_result", 32'(OUT_RESULT), 'h0030);
    check("logic_unit", 32'(OUT_UNIT), 1);
    check("logic_err", 32'(OUT_ERR), 0);
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;

    // Timeout: shift flag never comes, other flags held high
    IN_VALID = 1'b1; IN_A = 8'd3; IN_B = 8'd1; IN_FUN = 4'b1100;
    tick();
    IN_VALID = 1'b0;
    check("shift_issue_en", 32'(UNIT_EN), 'b1000);
    UNIT_FLAG = 4'b0111;
    tick();
    for (int i = 1; i < TO; i++) begin
      check("to_wait_valid", 32'(OUT_VALID), 0);
      tick();
    end
    check("to_last_wait_valid", 32'(OUT_VALID), 0);
    tick();
    UNIT_FLAG = '0;
    check("to_valid", 32'(OUT_VALID), 1);
    check("to_result", 32'(OUT_RESULT), 0);
    check("to_err", 32'(OUT_ERR), 1);
    check("to_unit", 32'(OUT_UNIT), 3);
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;

    // Flag arrives on the terminal-count cycle: flag wins
    IN_VALID = 1'b1; IN_FUN = 4'b1101;
    tick();
    IN_VALID = 1'b0;
    tick();
    for (int i = 1; i < TO; i++) tick();
    UNIT_FLAG = 4'b1000; SHIFT_OUT = 8'h18;
    tick();
    UNIT_FLAG = '0;
    check("race_valid", 32'(OUT_VALID), 1);
    check("race_err", 32'(OUT_ERR), 0);
    check("race_result", 32'(OUT_RESULT), 'h0018);
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;

    // Reset while waiting discards the request
    IN_VALID = 1'b1; IN_A = 8'd9; IN_B = 8'd7; IN_FUN = 4'b1011;
    tick();
    IN_VALID = 1'b0;
    tick();
    RST = 1'b0;
    #1;
    check("mid_rst_valid", 32'(OUT_VALID), 0);
    check("mid_rst_unit_a", 32'(UNIT_A), 0);
    check("mid_rst_unit_fun", 32'(UNIT_FUN), 0);
    check("mid_rst_result", 32'(OUT_RESULT), 0);
    check("mid_rst_unit", 32'(OUT_UNIT), 0);
    check("mid_rst_ready", 32'(IN_READY), 0);
    UNIT_FLAG = 4'b0100; CMP_OUT = 4'd1;
    #3;
    RST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_no_valid", 32'(OUT_VALID), 0);
      check("post_rst_no_en", 32'(UNIT_EN), 0);
    end
    check("post_rst_ready", 32'(IN_READY), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
